mips16_multi_cycle_core: RTL and testbench
==========================================

# mips16_multi_cycle_core

Parametrised multi-cycle successor to the 16-bit single-cycle MIPS core. It executes the same 4-bit-opcode ISA plus BEQ, AND and HALT through a FETCH/DECODE/EXEC/MEM/WB state machine. Instruction memory is host-loadable, and a run/halt handshake plus a stall input make the core steppable. It sits under the TinyTapeout top level in place of the single-cycle CPU, with `alu_out` driving the output pins.

## Interface
- DATA_W, 16, datapath and register width (≥8)
- IMEM_AW, 4, instruction-memory word-address width (depth 2^IMEM_AW, 16-bit words)
- DMEM_AW, 6, data-memory word-address width (depth 2^DMEM_AW, DATA_W words)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  leave HALT and begin fetching at current pc
- step_en  in  1  1 = FSM advances; 0 = all non-HALT state frozen
- prog_we  in  1  instruction-memory write strobe, honoured only in HALT
- prog_addr  in  IMEM_AW  instruction write address
- prog_data  in  16  instruction write data
- alu_out  out  DATA_W  registered ALU result of last EXEC
- pc_out  out  IMEM_AW  current pc (word index)
- halted  out  1  state == HALT
- retire  out  1  one-cycle pulse in the final state of each instruction

## Operation
- ISA, fields [15:12] op, [11:8] a, [7:4] b, [3:0] c; imm = sign-extend(c) to DATA_W:
  - 0 ADD rd=a, rs=b, rt=c
  - 1 SUB rd=a, rs=b, rt=c
  - 2 ADDI rd=a, rs=b
  - 3 LW rd=a, address rs=b + imm
  - 4 SW rt=a, address rs=b + imm
  - 5 J, pc = instr[IMEM_AW-1:0]
  - 6 XOR, same fields as ADD
  - 7 OR, same fields as ADD
  - 8 BEQ rs=a, rt=b; if equal, pc = pc+1+imm, else pc+1
  - 9 AND, same fields as ADD
  - F HALT
  - A–E: NOP.
- Register file: 16×DATA_W. r0 reads 0, and writes to r0 are dropped. r1..r15 reset to 0.
- States and transitions:
  - HALT → FETCH on run=1.
  - FETCH: IR←imem[pc], pc←pc+1, → DECODE.
  - DECODE: A←r[rs], B←r[rt]. HALT/NOP → HALT/FETCH, with retire.
  - EXEC: alu_out←ALU(A, B or imm). J/BEQ update pc, retire, → FETCH. LW/SW → MEM. Others → WB.
  - MEM: SW writes dmem[alu_out[DMEM_AW-1:0]]←B, retire, → FETCH. LW captures MDR, → WB.
  - WB: r[rd]←(LW ? MDR : alu_out), retire, → FETCH.
- Arithmetic is modulo 2^DATA_W. pc arithmetic is modulo 2^IMEM_AW, so the last word wraps to 0. Memory addresses are truncated to DMEM_AW bits.
- Memories are not reset; contents survive rst.

## Timing
- Reset values:
  - state HALT
  - pc_out 0
  - alu_out 0
  - halted 1
  - retire 0
  - IR 0
  - registers 0
- Cycles per instruction, from FETCH entry to retire:
  - J, BEQ, SW: 3/3/4 (J and BEQ retire in EXEC, SW in MEM)
  - ALU ops: 4
  - LW: 5
  - NOP and HALT: 2
- retire is high exactly one cycle per instruction, in that instruction's final state.
- step_en=0 freezes the state, pc, IR, A, B, alu_out and all memory writes. retire is held low during the stall and asserts in the first enabled cycle of the final state. step_en is ignored in HALT.
- prog_we in HALT writes at the clock edge. If run is high in the same cycle, the following FETCH sees the new word. prog_we outside HALT is ignored.
- rst has priority over run, prog_we and step_en. Mid-instruction reset aborts with no register or dmem write in that cycle.
- run outside HALT is ignored. A HALT instruction leaves pc pointing at the following word, so a later run resumes there.

## Structure
- Package mips16_pkg holds:
  - opcode localparams OP_ADD..OP_HALT
  - state encoding ST_HALT, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB (3 bits)
  - field-slice constants
- Sub-module mips16_alu, parametrised by DATA_W: combinational ADD/SUB/XOR/OR/AND plus an equality flag for BEQ.
- The register file, both memories and the FSM stay in the top module.

## Test plan
- Reset → halted=1, pc_out=0, alu_out=0. run with no program loaded (NOPs) → retire every 2 cycles and pc increments.
- Load ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT, then run → alu_out values 5, 0xFFFD, 2. halted rises after 14 cycles. pc_out=4.
- SW r3,0(r0) then LW r4,0(r0); ADD r5,r4,r0 → alu_out=2. The LW retire comes 5 cycles after its FETCH.
- BEQ r1,r1,+2 skips 2 words; BEQ r1,r2 falls through. J 15 then NOP → pc wraps 15→0 with IMEM_AW=4.
- step_en held low for 3 cycles mid-EXEC → state, pc and alu_out unchanged, retire delayed by exactly 3 cycles.
- rst asserted during WB of ADD r6 → r6 stays 0 and state is HALT on the next cycle. prog_we during FETCH → instruction memory is unchanged.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared definitions for the multi-cycle MIPS16 core: opcodes, FSM states,
// ALU operation select and instruction field positions.
package mips16_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_LW   = 4'h3;
  localparam logic [3:0] OP_SW   = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_XOR = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4
  } alu_op_t;

  localparam int unsigned OP_HI = 15;
  localparam int unsigned OP_LO = 12;
  localparam int unsigned FA_HI = 11;
  localparam int unsigned FA_LO = 8;
  localparam int unsigned FB_HI = 7;
  localparam int unsigned FB_LO = 4;
  localparam int unsigned FC_HI = 3;
  localparam int unsigned FC_LO = 0;

  // Opcodes 0xA..0xE are architectural no-ops.
  function automatic logic is_nop_op(input logic [3:0] op);
    return (op >= 4'hA) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/mips16_alu.sv
// Combinational ALU for the MIPS16 core with an equality flag used by BEQ.
module mips16_alu
  import mips16_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] y,
  output logic              eq
);

  always_comb begin
    y = a + b;
    case (op)
      ALU_SUB: y = a - b;
      ALU_XOR: y = a ^ b;
      ALU_OR:  y = a | b;
      ALU_AND: y = a & b;
      default: y = a + b;
    endcase
    eq = (a == b);
  end

endmodule

// File: rtl/mips16_multi_cycle_core.sv
// Multi-cycle 16-bit MIPS core: FETCH/DECODE/EXEC/MEM/WB FSM with a host-loadable
// instruction memory, run/halt handshake and a global stall (step_en).
module mips16_multi_cycle_core
  import mips16_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IMEM_AW = 4,
  parameter int DMEM_AW = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step_en,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [15:0]        prog_data,
  output logic [DATA_W-1:0]  alu_out,
  output logic [IMEM_AW-1:0] pc_out,
  output logic               halted,
  output logic               retire
);

  state_t             state, state_nx;
  logic [IMEM_AW-1:0] pc;
  logic [15:0]        ir;
  logic [DATA_W-1:0]  a_q, b_q, mdr, alu_q;
  logic [DATA_W-1:0]  alu_y, alu_b, imm;
  logic               alu_eq;
  alu_op_t            alu_op;
  logic [3:0]         op, fa, fb, fc, rs, rt;
  logic               is_j, is_beq, is_lw, is_sw, is_halt, is_nop;
  logic               reg_we, dmem_we;

  logic [DATA_W-1:0]  regs [16];
  logic [15:0]        imem [2**IMEM_AW];
  logic [DATA_W-1:0]  dmem [2**DMEM_AW];

  assign op  = ir[OP_HI:OP_LO];
  assign fa  = ir[FA_HI:FA_LO];
  assign fb  = ir[FB_HI:FB_LO];
  assign fc  = ir[FC_HI:FC_LO];
  assign imm = {{(DATA_W-4){fc[3]}}, fc};

  assign is_j    = (op == OP_J);
  assign is_beq  = (op == OP_BEQ);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_halt = (op == OP_HALT);
  assign is_nop  = is_nop_op(op);

  // BEQ reads (a,b), SW reads its store data from a; everything else uses (b,c).
  assign rs = is_beq ? fa : fb;
  assign rt = is_sw ? fa : (is_beq ? fb : fc);

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b_q;
    case (op)
      OP_SUB, OP_BEQ:        alu_op = ALU_SUB;
      OP_XOR:                alu_op = ALU_XOR;
      OP_OR:                 alu_op = ALU_OR;
      OP_AND:                alu_op = ALU_AND;
      OP_ADDI, OP_LW, OP_SW: alu_b  = imm;
      default:               ;
    endcase
  end

  mips16_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (a_q),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y),
    .eq (alu_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_HALT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_HALT:   if (run) state_nx = ST_FETCH;
      ST_FETCH:  if (step_en) state_nx = ST_DECODE;
      ST_DECODE: if (step_en) begin
        if (is_halt)     state_nx = ST_HALT;
        else if (is_nop) state_nx = ST_FETCH;
        else             state_nx = ST_EXEC;
      end
      ST_EXEC:   if (step_en) begin
        if (is_j || is_beq)     state_nx = ST_FETCH;
        else if (is_lw || is_sw) state_nx = ST_MEM;
        else                    state_nx = ST_WB;
      end
      ST_MEM:    if (step_en) state_nx = is_sw ? ST_FETCH : ST_WB;
      ST_WB:     if (step_en) state_nx = ST_FETCH;
      default:   state_nx = ST_HALT;
    endcase
  end

  always_comb begin
    retire  = 1'b0;
    reg_we  = 1'b0;
    dmem_we = 1'b0;
    halted  = (state == ST_HALT);
    if (step_en) begin
      case (state)
        ST_DECODE: retire = is_halt || is_nop;
        ST_EXEC:   retire = is_j || is_beq;
        ST_MEM: begin
          retire  = is_sw;
          dmem_we = is_sw;
        end
        ST_WB: begin
          retire = 1'b1;
          reg_we = (fa != 4'd0);
        end
        default: ;
      endcase
    end
  end

  // pc already points past the current word in EXEC, so BEQ adds imm directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      ir    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mdr   <= '0;
      alu_q <= '0;
    end else if (step_en) begin
      case (state)
        ST_FETCH: begin
          ir <= imem[pc];
          pc <= pc + 1'b1;
        end
        ST_DECODE: begin
          a_q <= regs[rs];
          b_q <= regs[rt];
        end
        ST_EXEC: begin
          alu_q <= alu_y;
          if (is_j)                 pc <= ir[IMEM_AW-1:0];
          else if (is_beq && alu_eq) pc <= pc + imm[IMEM_AW-1:0];
        end
        ST_MEM: if (is_lw) mdr <= dmem[alu_q[DMEM_AW-1:0]];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[fa] <= is_lw ? mdr : alu_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && halted && prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst && dmem_we) dmem[alu_q[DMEM_AW-1:0]] <= b_q;
  end

  assign alu_out = alu_q;
  assign pc_out  = pc;

endmodule

// File: tb/tb_mips16_multi_cycle_core.sv
// Directed bench for mips16_multi_cycle_core: small hand-assembled programs with
// hand-computed retire timing, ALU results and pc values.
module tb_mips16_multi_cycle_core;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step_en;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [15:0] alu_out;
  logic [3:0]  pc_out;
  logic        halted;
  logic        retire;

  int n_assert = 0;
  int n_fail   = 0;

  int          ret_at  [$];
  logic [15:0] ret_alu [$];
  logic [3:0]  ret_pc  [$];

  mips16_multi_cycle_core #(.DATA_W(16), .IMEM_AW(4), .DMEM_AW(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_en   (step_en),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .alu_out   (alu_out),
    .pc_out    (pc_out),
    .halted    (halted),
    .retire    (retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int at(input int k);
    return (k < ret_at.size()) ? ret_at[k] : -1;
  endfunction
  function automatic logic [15:0] alu_at(input int k);
    return (k < ret_alu.size()) ? ret_alu[k] : 16'hDEAD;
  endfunction
  function automatic logic [3:0] pc_at(input int k);
    return (k < ret_pc.size()) ? ret_pc[k] : 4'hX;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] addr, input logic [15:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Pulse run, then sample once per cycle (sample 0 = FETCH of the first
  // instruction), logging every retire until halted or the budget expires.
  task automatic run_trace(input int max_c, input bit fetch_poke, output int halt_at);
    ret_at.delete(); ret_alu.delete(); ret_pc.delete();
    halt_at = -1;
    run = 1'b1;
    tick();
    run = 1'b0;
    prog_we = 1'b0;
    for (int c = 0; c < max_c; c++) begin
      if (halted) begin
        halt_at = c;
        break;
      end
      if (retire) begin
        ret_at.push_back(c);
        ret_alu.push_back(alu_out);
        ret_pc.push_back(pc_out);
      end
      if (fetch_poke && c == 0) begin
        prog_we = 1'b1; prog_addr = 4'd5; prog_data = 16'h2D07;
      end
      tick();
      prog_we = 1'b0;
    end
    if (halt_at < 0) begin
      n_assert++; n_fail++;
      $display("FAIL run_timeout: halted never rose within %0d cycles", max_c);
    end
  endtask

  task automatic test_reset();
    run = 1'b0; step_en = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    do_reset();
    n_assert++; if (halted !== 1'b1) begin n_fail++; $display("FAIL reset_halted: got %b want 1", halted); end
    n_assert++; if (pc_out !== 4'd0) begin n_fail++; $display("FAIL reset_pc: got %0d want 0", pc_out); end
    n_assert++; if (alu_out !== 16'h0000) begin n_fail++; $display("FAIL reset_alu: got %h want 0000", alu_out); end
    n_assert++; if (retire !== 1'b0) begin n_fail++; $display("FAIL reset_retire: got %b want 0", retire); end
  endtask

  task automatic test_nop_run();
    int h;
    for (int i = 0; i < 16; i++) load(4'(i), (i == 2) ? 16'hF000 : 16'hA000);
    run_trace(40, 1'b0, h);
    n_assert++; if (at(0) != 1) begin n_fail++; $display("FAIL nop_retire0: got %0d want 1", at(0)); end
    n_assert++; if (at(1) != 3) begin n_fail++; $display("FAIL nop_retire1: got %0d want 3", at(1)); end
    n_assert++; if (at(2) != 5) begin n_fail++; $display("FAIL nop_halt_retire: got %0d want 5", at(2)); end
    n_assert++; if (pc_at(1) !== 4'd2) begin n_fail++; $display("FAIL nop_pc_inc: got %0d want 2", pc_at(1)); end
    n_assert++; if (h != 6) begin n_fail++; $display("FAIL nop_halt_at: got %0d want 6", h); end
    n_assert++; if (pc_out !== 4'd3) begin n_fail++; $display("FAIL nop_final_pc: got %0d want 3", pc_out); end
  endtask

  task automatic test_alu_prog();
    int h;
    do_reset();
    load(4'd0, 16'h2105);  // ADDI r1,r0,5
    load(4'd1, 16'h220D);  // ADDI r2,r0,-3
    load(4'd2, 16'h0312);  // ADD  r3,r1,r2
    load(4'd3, 16'hF000);  // HALT
    run_trace(60, 1'b0, h);
    n_assert++; if (alu_at(0) !== 16'h0005) begin n_fail++; $display("FAIL alu_addi5: got %h want 0005", alu_at(0)); end
    n_assert++; if (alu_at(1) !== 16'hFFFD) begin n_fail++; $display("FAIL alu_addi_neg3: got %h want fffd", alu_at(1)); end
    n_assert++; if (alu_at(2) !== 16'h0002) begin n_fail++; $display("FAIL alu_add: got %h want 0002", alu_at(2)); end
    n_assert++; if (at(2) != 11) begin n_fail++; $display("FAIL alu_add_retire: got %0d want 11", at(2)); end
    n_assert++; if (h != 14) begin n_fail++; $display("FAIL alu_halt_at: got %0d want 14", h); end
    n_assert++; if (pc_out !== 4'd4) begin n_fail++; $display("FAIL alu_final_pc: got %0d want 4", pc_out); end
  endtask

  task automatic test_mem();
    int h;
    load(4'd4, 16'h4300);  // SW  r3,0(r0)
    load(4'd5, 16'h3400);  // LW  r4,0(r0)
    load(4'd6, 16'h0540);  // ADD r5,r4,r0
    load(4'd7, 16'hF000);  // HALT
    run_trace(60, 1'b0, h);
    n_assert++; if (at(0) != 3) begin n_fail++; $display("FAIL mem_sw_retire: got %0d want 3", at(0)); end
    n_assert++; if (at(1) != 8) begin n_fail++; $display("FAIL mem_lw_retire: got %0d want 8", at(1)); end
    n_assert++; if (alu_at(2) !== 16'h0002) begin n_fail++; $display("FAIL mem_lw_data: got %h want 0002", alu_at(2)); end
    n_assert++; if (h != 15) begin n_fail++; $display("FAIL mem_halt_at: got %0d want 15", h); end
  endtask

  task automatic test_branch();
    int h;
    load(4'd8,  16'h8112);  // BEQ r1,r1,+2 -> 11
    load(4'd9,  16'h2601);  // skipped
    load(4'd10, 16'h2601);  // skipped
    load(4'd11, 16'h8122);  // BEQ r1,r2 not taken
    load(4'd12, 16'h2707);  // ADDI r7,r0,7
    load(4'd13, 16'h500F);  // J 15
    load(4'd14, 16'hF000);  // skipped
    load(4'd15, 16'hA000);  // NOP, pc wraps
    load(4'd0,  16'hF000);  // HALT
    run_trace(60, 1'b0, h);
    n_assert++; if (ret_at.size() != 6) begin n_fail++; $display("FAIL br_retire_count: got %0d want 6", ret_at.size()); end
    n_assert++; if (at(0) != 2) begin n_fail++; $display("FAIL br_beq_cycles: got %0d want 2", at(0)); end
    n_assert++; if (pc_at(1) !== 4'd12) begin n_fail++; $display("FAIL br_taken_target: got %0d want 12", pc_at(1)); end
    n_assert++; if (pc_at(2) !== 4'd13) begin n_fail++; $display("FAIL br_fallthrough: got %0d want 13", pc_at(2)); end
    n_assert++; if (alu_at(2) !== 16'h0007) begin n_fail++; $display("FAIL br_addi7: got %h want 0007", alu_at(2)); end
    n_assert++; if (pc_at(4) !== 4'd0) begin n_fail++; $display("FAIL br_pc_wrap: got %0d want 0", pc_at(4)); end
    n_assert++; if (h != 17) begin n_fail++; $display("FAIL br_halt_at: got %0d want 17", h); end
    n_assert++; if (pc_out !== 4'd1) begin n_fail++; $display("FAIL br_final_pc: got %0d want 1", pc_out); end
  endtask

  task automatic test_stall();
    logic [15:0] hold;
    int n;
    load(4'd1, 16'h2803);  // ADDI r8,r0,3
    load(4'd2, 16'hF000);  // HALT
    step_en = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    n_assert++; if (halted !== 1'b0) begin n_fail++; $display("FAIL stall_run_in_halt: halted got %b want 0", halted); end
    step_en = 1'b1;
    tick();
    tick();  // now in EXEC
    hold = alu_out;
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_assert++; if (pc_out !== 4'd2) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0d want 2", i, pc_out); end
      n_assert++; if (alu_out !== hold) begin n_fail++; $display("FAIL stall_alu[%0d]: got %h want %h", i, alu_out, hold); end
      n_assert++; if (retire !== 1'b0) begin n_fail++; $display("FAIL stall_retire[%0d]: got %b want 0", i, retire); end
    end
    step_en = 1'b1;
    tick();  // WB, sample 6 instead of 3
    n_assert++; if (retire !== 1'b1) begin n_fail++; $display("FAIL stall_delayed_retire: got %b want 1", retire); end
    n_assert++; if (alu_out !== 16'h0003) begin n_fail++; $display("FAIL stall_alu_result: got %h want 0003", alu_out); end
    n = 0;
    while (!halted && n < 10) begin tick(); n++; end
    n_assert++; if (halted !== 1'b1 || pc_out !== 4'd3) begin n_fail++; $display("FAIL stall_end: halted %b pc %0d want 1 pc 3", halted, pc_out); end
  endtask

  task automatic test_reset_abort();
    int h;
    load(4'd3, 16'h0611);  // ADD r6,r1,r1
    run = 1'b1;
    tick();
    run = 1'b0;
    tick(); tick(); tick();  // WB
    n_assert++; if (retire !== 1'b1) begin n_fail++; $display("FAIL abort_in_wb: retire got %b want 1", retire); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_assert++; if (halted !== 1'b1) begin n_fail++; $display("FAIL abort_halted: got %b want 1", halted); end
    n_assert++; if (pc_out !== 4'd0 || alu_out !== 16'h0000) begin n_fail++; $display("FAIL abort_state: pc %0d alu %h want 0 0000", pc_out, alu_out); end
    load(4'd0, 16'h0960);  // ADD r9,r6,r0
    load(4'd1, 16'h3A00);  // LW  r10,0(r0)
    load(4'd2, 16'h0BA0);  // ADD r11,r10,r0
    load(4'd3, 16'hF000);  // HALT
    run_trace(60, 1'b0, h);
    n_assert++; if (alu_at(0) !== 16'h0000) begin n_fail++; $display("FAIL abort_r6: got %h want 0000", alu_at(0)); end
    n_assert++; if (alu_at(2) !== 16'h0002) begin n_fail++; $display("FAIL abort_dmem_kept: got %h want 0002", alu_at(2)); end
    n_assert++; if (h != 15) begin n_fail++; $display("FAIL abort_halt_at: got %0d want 15", h); end
  endtask

  task automatic test_prog_we();
    int h;
    load(4'd5, 16'hF000);  // HALT
    prog_we = 1'b1; prog_addr = 4'd4; prog_data = 16'h2C04;  // ADDI r12,r0,4 written with run
    run_trace(40, 1'b1, h);
    n_assert++; if (alu_at(0) !== 16'h0004) begin n_fail++; $display("FAIL pw_same_cycle_run: got %h want 0004", alu_at(0)); end
    n_assert++; if (ret_at.size() != 2) begin n_fail++; $display("FAIL pw_retire_count: got %0d want 2", ret_at.size()); end
    n_assert++; if (h != 6) begin n_fail++; $display("FAIL pw_fetch_write_ignored: halt_at %0d want 6", h); end
    n_assert++; if (pc_out !== 4'd6) begin n_fail++; $display("FAIL pw_final_pc: got %0d want 6", pc_out); end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step_en = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    test_reset();
    test_nop_run();
    test_alu_prog();
    test_mem();
    test_branch();
    test_stall();
    test_reset_abort();
    test_prog_we();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
